// File: rtl/point_frame_tx.sv
// point_frame_tx
// Serializes a drawing list of 25-bit vector points into the framed 8N1 byte
// stream expected by the display's UART point receiver.
//
// Frame: A5, cnt_lo, cnt_hi, { w[7:0], w[15:8], w[23:16], {7'b0,w[24]} } x N,
//        checksum (XOR of every byte after A5).
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           request one frame (sampled only in IDLE)
//   num_points      point count, latched when start is accepted
//   rd_addr         point RAM read address
//   rd_data         point RAM data, valid one cycle after rd_addr
//   tx              UART line, idle high
//   busy            high while a frame is in progress
//   done            one-cycle pulse at frame completion
//   dbg_top_state   current frame-level FSM state
//   dbg_ser_state   current bit-serializer state
//
// Handshake: start is a level request; it is accepted on any clock edge where
// the FSM is in IDLE, and ignored otherwise. There is no backpressure on tx.
module point_frame_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] num_points,
  output logic [10:0] rd_addr,
  input  logic [24:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [3:0]  dbg_top_state,
  output logic [1:0]  dbg_ser_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_CNT_LO, S_CNT_HI,
    S_PT_B0, S_PT_B1, S_PT_B2, S_PT_B3,
    S_CSUM, S_FIN
  } top_state_t;

  typedef enum logic [1:0] {
    SER_START, SER_DATA, SER_STOP
  } ser_state_t;

  top_state_t    state_q, state_d;
  ser_state_t    ser_q, ser_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [10:0]   n_q, n_d;
  logic [10:0]   addr_q, addr_d;
  logic [24:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;

  logic [7:0]    cur_byte;
  logic          bit_end;
  logic          sending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ser_q   <= SER_START;
      cnt_q   <= '0;
      idx_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      ser_q   <= ser_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  // Byte currently on the wire is a pure function of the frame state, so no
  // separate shift register is needed.
  always_comb begin
    cur_byte = 8'h00;
    case (state_q)
      S_SYNC:   cur_byte = 8'hA5;
      S_CNT_LO: cur_byte = n_q[7:0];
      S_CNT_HI: cur_byte = {5'b0, n_q[10:8]};
      S_PT_B0:  cur_byte = word_q[7:0];
      S_PT_B1:  cur_byte = word_q[15:8];
      S_PT_B2:  cur_byte = word_q[23:16];
      S_PT_B3:  cur_byte = {7'b0, word_q[24]};
      S_CSUM:   cur_byte = csum_q;
      default:  cur_byte = 8'h00;
    endcase
  end

  assign sending = (state_q != S_IDLE) && (state_q != S_FIN);
  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    n_d     = n_q;
    addr_d  = addr_q;
    word_d  = word_q;
    csum_d  = csum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SYNC;
          ser_d   = SER_START;
          cnt_d   = '0;
          idx_d   = '0;
          n_d     = num_points;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!bit_end) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          case (ser_q)
            SER_START: begin
              ser_d = SER_DATA;
              idx_d = '0;
            end
            SER_DATA: begin
              if (idx_q == 3'd7) ser_d = SER_STOP;
              else               idx_d = idx_q + 3'd1;
            end
            default: begin
              // Stop bit finished: the next byte's start bit follows
              // immediately, with no idle gap.
              ser_d = SER_START;
              if (state_q != S_SYNC && state_q != S_CSUM)
                csum_d = csum_q ^ cur_byte;
              case (state_q)
                S_SYNC:   state_d = S_CNT_LO;
                S_CNT_LO: state_d = S_CNT_HI;
                S_CNT_HI: state_d = (n_q != 11'd0) ? S_PT_B0 : S_CSUM;
                S_PT_B0:  state_d = S_PT_B1;
                S_PT_B1:  state_d = S_PT_B2;
                S_PT_B2:  state_d = S_PT_B3;
                // addr_q already counts the points fetched so far.
                S_PT_B3:  state_d = (addr_q != n_q) ? S_PT_B0 : S_CSUM;
                default:  state_d = S_FIN;
              endcase
              // The word register is loaded on the edge that enters PT_B0,
              // so it is valid from the first cycle of that state; the
              // address has been stable since the previous fetch.
              if (state_d == S_PT_B0) begin
                word_d = rd_data;
                addr_d = addr_q + 11'd1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (sending) begin
      case (ser_q)
        SER_START: tx = 1'b0;
        SER_DATA:  tx = cur_byte[idx_q];
        default:   tx = 1'b1;
      endcase
    end
  end

  assign busy          = sending;
  assign done          = (state_q == S_FIN);
  assign rd_addr       = addr_q;
  assign dbg_top_state = state_q;
  assign dbg_ser_state = ser_q;

endmodule

// File: tb/tb_point_frame_tx.sv
module tb_point_frame_tx;

  localparam int CPB  = 4;
  localparam int BYTE = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] num_points = '0;
  logic [10:0] rd_addr;
  logic [24:0] rd_data = '0;
  logic        tx, busy, done;
  logic [3:0]  dbg_top_state;
  logic [1:0]  dbg_ser_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  point_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start), .num_points(num_points),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx(tx), .busy(busy), .done(done),
    .dbg_top_state(dbg_top_state), .dbg_ser_state(dbg_ser_state)
  );

  // Synchronous point RAM model.
  logic [24:0] ram [0:2047];
  always @(posedge clk) rd_data <= ram[rd_addr];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  // {first_byte_of_frame, byte}
  logic [8:0]  exp_q[$];
  logic [10:0] addr_log[$];
  logic [10:0] prev_addr = '0;
  int          done_cnt = 0;
  int          frame_start_cyc = 0;
  logic        mon_abort = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [10:0] n);
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [24:0] w;
    exp_q.push_back({1'b1, 8'hA5});
    b = n[7:0];            exp_q.push_back({1'b0, b}); cs = b;
    b = {5'b0, n[10:8]};   exp_q.push_back({1'b0, b}); cs ^= b;
    for (int i = 0; i < int'(n); i++) begin
      w = ram[i];
      b = w[7:0];          exp_q.push_back({1'b0, b}); cs ^= b;
      b = w[15:8];         exp_q.push_back({1'b0, b}); cs ^= b;
      b = w[23:16];        exp_q.push_back({1'b0, b}); cs ^= b;
      b = {7'b0, w[24]};   exp_q.push_back({1'b0, b}); cs ^= b;
    end
    exp_q.push_back({1'b0, cs});
  endtask

  task automatic push_bytes(input logic [7:0] bl[$]);
    for (int i = 0; i < bl.size(); i++) exp_q.push_back({(i == 0), bl[i]});
  endtask

  // ---------------- monitors ----------------
  task automatic mon_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      if (reset) mon_abort = 1'b1;
    end
  endtask

  // UART decoder: pops and compares each received byte, and checks that
  // consecutive bytes of a frame start exactly one byte time apart.
  initial begin : decoder
    int         s;
    int         last_s;
    logic [7:0] rx;
    logic       stop_b;
    logic [8:0] e;
    last_s = 0;
    forever begin
      @(negedge clk);
      if (!reset && tx == 1'b0) begin
        s = cyc;
        mon_abort = 1'b0;
        mon_wait(CPB / 2);
        for (int b = 0; b < 8; b++) begin
          mon_wait(CPB);
          rx[b] = tx;
        end
        mon_wait(CPB);
        stop_b = tx;
        if (!mon_abort) begin
          check("stop_bit", 32'(stop_b), 32'd1);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(rx), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(rx), 32'(e[7:0]));
            if (e[8]) frame_start_cyc = s;
            else      check("byte_gap", 32'(s - last_s), 32'(BYTE));
          end
          last_s = s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      done_cnt++;
      check("done_busy", 32'(busy), 32'd0);
      check("done_tx", 32'(tx), 32'd1);
    end
    if (rd_addr != prev_addr) addr_log.push_back(rd_addr);
    prev_addr = rd_addr;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [10:0] n);
    num_points = n;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_tx", 32'(tx), 32'd0);
  endtask

  task automatic wait_done(input int budget, output int dc);
    logic found;
    found = 1'b0;
    dc = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        dc = cyc;
      end
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int          dc, d1, dn0;
    logic [7:0]  bl[$];
    for (int i = 0; i < 2048; i++) ram[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    reset = 1'b0;
    idle(3);

    // Zero points
    addr_log.delete();
    dn0 = done_cnt;
    bl = '{8'hA5, 8'h00, 8'h00, 8'h00};
    push_bytes(bl);
    send(11'd0);
    wait_done(400, dc);
    check("n0_len", 32'(dc - frame_start_cyc), 32'd160);
    idle(20);
    check("n0_done_cnt", 32'(done_cnt - dn0), 32'd1);
    check("n0_addr_moves", 32'(addr_log.size()), 32'd0);
    check("n0_queue_empty", 32'(exp_q.size()), 32'd0);

    // Single point
    ram[0] = 25'h1ABC123;
    bl = '{8'hA5, 8'h01, 8'h00, 8'h23, 8'hC1, 8'hAB, 8'h01, 8'h49};
    push_bytes(bl);
    send(11'd1);
    wait_done(800, dc);
    check("n1_len", 32'(dc - frame_start_cyc), 32'd320);
    idle(10);
    check("n1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Multi-point fetch
    for (int i = 0; i < 3; i++) begin
      logic [11:0] xi, yi;
      logic [31:0] iv;
      iv = i;
      xi = 12'h100 + 12'(i);
      yi = 12'h200 + 12'(i);
      ram[i] = {iv[0], xi, yi};
    end
    addr_log.delete();
    push_frame(11'd3);
    send(11'd3);
    wait_done(1200, dc);
    check("n3_len", 32'(dc - frame_start_cyc), 32'(16 * BYTE));
    check("n3_addr_end", 32'(rd_addr), 32'd3);
    check("n3_addr_moves", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < addr_log.size() && i < 4; i++)
      check("n3_addr_seq", 32'(addr_log[i]), 32'(i));
    idle(10);
    check("n3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start while busy
    ram[0] = 25'h0F0F0F0; ram[1] = 25'h1234567;
    dn0 = done_cnt;
    push_frame(11'd2);
    send(11'd2);
    idle(100);
    num_points = 11'd5;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(1200, dc);
    idle(300);
    check("busy_start_done_cnt", 32'(done_cnt - dn0), 32'd1);
    check("busy_start_queue", 32'(exp_q.size()), 32'd0);
    check("busy_start_idle", 32'(busy), 32'd0);

    // Reset mid-frame, during the data bits of the first point's third byte
    ram[0] = 25'h0ABCDEF; ram[1] = 25'h1555AAA;
    dn0 = done_cnt;
    push_frame(11'd2);
    send(11'd2);
    idle(5 * BYTE + 10);
    reset = 1'b1;
    idle(1);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(60);
    check("mid_rst_no_done", 32'(done_cnt - dn0), 32'd0);
    check("mid_rst_bytes_seen", 32'(exp_q.size()), 32'd7);
    exp_q.delete();
    push_frame(11'd2);
    send(11'd2);
    wait_done(1200, dc);
    check("post_rst_len", 32'(dc - frame_start_cyc), 32'(12 * BYTE));
    idle(10);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    // Back-to-back frames with start held high
    ram[0] = 25'h1FFF000;
    dn0 = done_cnt;
    push_frame(11'd1);
    push_frame(11'd1);
    num_points = 11'd1;
    start = 1'b1;
    wait_done(800, d1);
    idle(2);
    start = 1'b0;
    wait_done(800, dc);
    check("b2b_gap", 32'(frame_start_cyc - d1), 32'd2);
    idle(100);
    check("b2b_done_cnt", 32'(done_cnt - dn0), 32'd2);
    check("b2b_queue", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
